mdu32: RTL and testbench

- Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers of the pipelined MIPS datapath.
- Launched from the EX stage; hi/lo are consumed downstream by the 32-bit result select mux, alongside the ALU result, for MFHI/MFLO.
- The busy output drives the hazard unit, which stalls any MFHI/MFLO/mult/div that issues while an operation is in flight.

---
 rtl/mdu32.sv | 191 +++++++++++++++++++
 tb/tb_mdu32.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu32.sv
// mdu32: iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Operands are reduced to magnitudes at launch, a radix-2 shift-add or
// restoring shift-subtract runs for WIDTH cycles, then one FIX cycle applies
// the sign correction and writes HI/LO.
//
// Handshake: start is a one-cycle strobe, acted on only while busy=0 and
// flush=0; busy is high from the cycle after launch until the result is
// written; done is a one-cycle pulse in the cycle after HI/LO are updated by
// a completed mult/div (never for MTHI/MTLO or aborted operations).
module mdu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4:0]         count;
  logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]   b_mag;    // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;    // negate product / quotient
  logic               neg_r;    // negate remainder
  logic               div_zero;

  logic               launch;
  logic               mt_hi;
  logic               mt_lo;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] step_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  assign busy = (state != IDLE);

  // Launch decode and operand magnitude extraction (ops 0/2 are signed).
  always_comb begin
    launch    = (state == IDLE) && start && !flush && !op[2];
    mt_hi     = (state == IDLE) && start && !flush && (op == 3'd4);
    mt_lo     = (state == IDLE) && start && !flush && (op == 3'd5);
    signed_op = !op[0];
    a_neg     = signed_op && srcA[WIDTH-1];
    b_neg     = signed_op && srcB[WIDTH-1];
    a_abs     = a_neg ? -srcA : srcA;
    b_abs     = b_neg ? -srcB : srcB;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_mag};
    step_nxt = acc;
    if (is_div) begin
      if (diff[WIDTH]) begin
        step_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        step_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction and HI/LO placement applied while in FIX.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      // Division by zero leaves the dividend in the remainder; the quotient
      // is forced to all ones regardless of sign.
      hi_fix = rem_fix;
      lo_fix = div_zero ? '1 : quo_fix;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush returns any busy state to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) state_nxt = CALC;
      end
      CALC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (count == 5'(WIDTH - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers, HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      b_mag    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            count    <= '0;
            b_mag    <= b_abs;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (srcB == '0);
            acc      <= {{WIDTH{1'b0}}, a_abs};
          end else if (mt_hi) begin
            hi <= srcA;
          end else if (mt_lo) begin
            lo <= srcA;
          end
        end
        CALC: begin
          if (!flush) begin
            acc   <= step_nxt;
            count <= count + 5'd1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= hi_fix;
            lo   <= lo_fix;
            done <= 1'b1;
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: directed-vector bench for mdu32 with a result scoreboard.
module tb_mdu32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  mdu32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Driver: one-cycle start strobe; returns at the negedge after the launch edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
  endtask

  // Count busy cycles until it drops (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Full mult/div: expected result enters the scoreboard, then timing is checked.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    exp_q.push_back({eh, el});
    issue(o, a, b);
    wait_idle(n);
    check({name, "_busy_cycles"}, 64'(n), 64'd33);
    check({name, "_done_high"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd7;
    srcA  = '0;
    srcB  = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_hilo", {hi, lo}, 64'd0);
      check("idle_flags", {62'd0, busy, done}, 64'd0);
    end

    // Multiply and divide vectors
    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg_neg", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m7_0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; srcA = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    op = OP_MTLO; srcA = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    check("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    check("mtlo_flags", {62'd0, busy, done}, 64'd0);

    // Start while busy is ignored
    exp_q.push_back({32'd0, 32'd12});
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MULT; srcA = 32'd100; srcB = 32'd100;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    wait_idle(n);
    check("busy_start_cycles", 64'(n), 64'd27);
    repeat (40) @(negedge clk);
    check("busy_start_hold", {hi, lo}, {32'd0, 32'd12});

    // Flush during CALC at count=10
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hold", {hi, lo}, {32'd0, 32'd12});
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Flush during FIX beats the write
    issue(OP_MULTU, 32'd3, 32'd3);
    repeat (32) @(negedge clk);
    check("fix_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fix_flush_idle", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    check("fix_flush_hold", {hi, lo}, {32'd2, 32'd14});

    // Flush in IDLE blocks MTHI
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; srcA = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 3'd7;
    check("idle_flush_mthi", {hi, lo}, {32'd2, 32'd14});
    check("idle_flush_busy", 64'(busy), 64'd0);

    // Reset during FIX
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (32) @(negedge clk);
    check("rst_fix_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_fix_hilo", {hi, lo}, 64'd0);
    check("rst_fix_flags", {62'd0, busy, done}, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_fix_hold", {hi, lo}, 64'd0);
    run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
